// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed 7-segment scanner: per-digit BLANK dead-time then DRIVE, frame-atomic shadows.
// Optional COLON_BLINK_EN: digit 2 DP follows a 1 Hz blink register; registered outputs, no backpressure.
module seg_scan_mux #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       tick_1hz,
  input  logic [7:0] seg_seconds_units,
  input  logic [7:0] seg_seconds_tens,
  input  logic [7:0] seg_minutes_units,
  input  logic [7:0] seg_minutes_tens,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

  state_t        r_state, w_state_nxt, w_slot_state;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_run;
  logic          w_capture;
  logic          w_drive;
  logic [7:0]    r_shadow [4];
  logic [7:0]    w_shadow_nxt [4];
  logic [7:0]    w_in [4];
  logic [7:0]    w_seg_drv;

  assign w_in[0] = seg_seconds_units;
  assign w_in[1] = seg_seconds_tens;
  assign w_in[2] = seg_minutes_units;
  assign w_in[3] = seg_minutes_tens;

  // With no dead-time each slot opens directly in DRIVE.
  assign w_slot_state = HAS_BLANK ? BLANK : DRIVE;

  // State registers describe the cycle being presented, so outputs are built from the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    if (!en) begin
      w_state_nxt = BLANK;
      w_idx_nxt   = 2'd0;
      w_cnt_nxt   = '0;
    end else if (!r_run) begin
      w_state_nxt = w_slot_state;
      w_idx_nxt   = 2'd0;
      w_cnt_nxt   = '0;
      w_capture   = 1'b1;
    end else if (r_state == BLANK) begin
      if (r_cnt == BLANK_LAST) begin
        w_state_nxt = DRIVE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end else if (r_cnt == DRIVE_LAST) begin
      w_state_nxt = w_slot_state;
      w_idx_nxt   = r_idx + 2'd1;
      w_cnt_nxt   = '0;
      w_capture   = (r_idx == 2'd3);
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_shadow_nxt[i] = w_capture ? w_in[i] : r_shadow[i];
    end
  end

  assign w_drive = en && (w_state_nxt == DRIVE);

`ifdef COLON_BLINK_EN
  logic r_blink;
  logic w_blink_nxt;

  assign w_blink_nxt = r_blink ^ (tick_1hz & en);

  always_comb begin
    w_seg_drv = w_shadow_nxt[w_idx_nxt];
    if (w_idx_nxt == 2'd2) begin
      w_seg_drv[7] = ~w_blink_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_blink <= 1'b0;
    else     r_blink <= w_blink_nxt;
  end
`else
  logic w_unused_tick;
  assign w_unused_tick = tick_1hz;
  assign w_seg_drv     = w_shadow_nxt[w_idx_nxt];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= BLANK;
      r_idx      <= 2'd0;
      r_cnt      <= '0;
      r_run      <= 1'b0;
      an         <= 4'b1111;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
      for (int i = 0; i < 4; i++) r_shadow[i] <= 8'hFF;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_run      <= en;
      an         <= w_drive ? ~(4'b0001 << w_idx_nxt) : 4'b1111;
      seg        <= w_drive ? w_seg_drv : 8'hFF;
      frame_done <= w_drive && (w_idx_nxt == 2'd3) && (w_cnt_nxt == DRIVE_LAST);
      for (int i = 0; i < 4; i++) r_shadow[i] <= w_shadow_nxt[i];
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: a 4/2 instance against a frame table plus a 1/0 instance for the DRIVE-only case.
module tb_seg_scan_mux;

  logic       clk = 1'b0;
  logic       rst, en, tick_1hz;
  logic [7:0] su, st, mu, mt;
  logic [3:0] an_a, an_b;
  logic [7:0] seg_a, seg_b;
  logic       fd_a, fd_b;

  int errors = 0;
  int checks = 0;
  int pos    = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .en(en), .tick_1hz(tick_1hz),
    .seg_seconds_units(su), .seg_seconds_tens(st),
    .seg_minutes_units(mu), .seg_minutes_tens(mt),
    .an(an_a), .seg(seg_a), .frame_done(fd_a)
  );

  seg_scan_mux #(.REFRESH_DIV(1), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .tick_1hz(tick_1hz),
    .seg_seconds_units(su), .seg_seconds_tens(st),
    .seg_minutes_units(mu), .seg_minutes_tens(mt),
    .an(an_b), .seg(seg_b), .frame_done(fd_b)
  );

  typedef struct {
    logic       en;
    logic [3:0] an;
    logic [7:0] seg;
    logic       fd;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // pos tracks the expected frame position of the 4/2 instance (0 = dark/idle).
  task automatic step();
    logic r_s, e_s;
    r_s = rst;
    e_s = en;
    @(posedge clk);
    #1;
    if (r_s || !e_s) pos = 0;
    else             pos = pos % 24 + 1;
  endtask

  task automatic run_to(input int target);
    for (int n = 0; n < 60 && pos != target; n++) step();
    checks++;
    if (pos != target) begin
      errors++;
      $display("FAIL run_to got=%0d want=%0d", pos, target);
    end
  endtask

  task automatic chk_dark(input string name, input int cyc);
    chk({name, "_an_a"}, cyc, {4'h0, an_a}, 8'h0F);
    chk({name, "_seg_a"}, cyc, seg_a, 8'hFF);
    chk({name, "_fd_a"}, cyc, {7'h0, fd_a}, 8'h00);
    chk({name, "_an_b"}, cyc, {4'h0, an_b}, 8'h0F);
    chk({name, "_seg_b"}, cyc, seg_b, 8'hFF);
  endtask

  initial begin
    int         seg_len [8];
    logic [3:0] seg_an  [8];
    logic [7:0] seg_pat [8];
    logic [7:0] exp_seg;
    logic [7:0] exp_d2 [3];
    int t;

    seg_len = '{2, 4, 2, 4, 2, 4, 2, 4};
    seg_an  = '{4'hF, 4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7};
    seg_pat = '{8'hFF, 8'hC0, 8'hFF, 8'hF9, 8'hFF, 8'hA4, 8'hFF, 8'hB0};
    t = 0;
    for (int s = 0; s < 8; s++) begin
      for (int j = 0; j < seg_len[s]; j++) begin
        tbl[t] = '{1'b1, seg_an[s], seg_pat[s], 1'b0};
        t++;
      end
    end
    tbl[23].fd = 1'b1;

`ifdef COLON_BLINK_EN
    exp_d2 = '{8'hA4, 8'h24, 8'hA4};
`else
    exp_d2 = '{8'h24, 8'h24, 8'h24};
`endif

    rst = 1'b1; en = 1'b1; tick_1hz = 1'b0;
    su = 8'hC0; st = 8'hF9; mu = 8'hA4; mt = 8'hB0;
    step();
    chk_dark("reset", 0);
    rst = 1'b0;

    // Two frames from the table; seg_minutes_tens changes mid-frame 1 and shows only in frame 2.
    for (int k = 1; k <= 48; k++) begin
      t = (k - 1) % 24;
      en = tbl[t].en;
      step();
      exp_seg = (k > 24 && tbl[t].seg == 8'hB0) ? 8'h99 : tbl[t].seg;
      chk("an_a", k, {4'h0, an_a}, {4'h0, tbl[t].an});
      chk("seg_a", k, seg_a, exp_seg);
      chk("fd_a", k, {7'h0, fd_a}, {7'h0, tbl[t].fd});
      chk("an_b", k, {4'h0, an_b}, {4'h0, ~(4'b0001 << ((k - 1) % 4))});
      chk("fd_b", k, {7'h0, fd_b}, {7'h0, (k % 4) == 0});
      if (k == 10) mt = 8'h99;
    end

    // Enable drop mid digit 1, new input while dark, fresh capture on re-enable.
    run_to(10);
    en = 1'b0;
    su = 8'h92;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_dark("en_low", i);
      chk("en_low_fd_b", i, {7'h0, fd_b}, 8'h00);
    end
    en = 1'b1;
    step();
    chk("en_rise_an_a", 1, {4'h0, an_a}, 8'h0F);
    chk("en_rise_seg_a", 1, seg_a, 8'hFF);
    chk("en_rise_an_b", 1, {4'h0, an_b}, 8'h0E);
    chk("en_rise_seg_b", 1, seg_b, 8'h92);
    run_to(3);
    chk("en_d0_an_a", 3, {4'h0, an_a}, 8'h0E);
    chk("en_d0_seg_a", 3, seg_a, 8'h92);

    // Reset pulse during digit 2 DRIVE.
    run_to(15);
    chk("pre_rst_an_a", 15, {4'h0, an_a}, 8'h0B);
    chk("pre_rst_seg_a", 15, seg_a, 8'hA4);
    rst = 1'b1;
    step();
    chk_dark("rst_mid", 0);
    rst = 1'b0;
    step();
    chk("rst_restart_an_a", 1, {4'h0, an_a}, 8'h0F);
    chk("rst_restart_an_b", 1, {4'h0, an_b}, 8'h0E);
    run_to(3);
    chk("rst_d0_an_a", 3, {4'h0, an_a}, 8'h0E);
    chk("rst_d0_seg_a", 3, seg_a, 8'h92);

    // Digit 2 DP with the colon pattern across two 1 Hz ticks.
    mu = 8'h24;
    run_to(24);
    for (int f = 0; f < 3; f++) begin
      run_to(15);
      chk("dp_an_a", f, {4'h0, an_a}, 8'h0B);
      chk("dp_seg_a", f, seg_a, exp_d2[f]);
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, sets the drive cycles per digit slot; it SHALL be at least 1.
REQ-002 Parameter BLANK_CYCLES, default 1000, sets the all-off dead-time cycles before each digit's drive phase; 0 SHALL be legal.
REQ-003 The ports SHALL be as follows; clock and reset first, with one clock and a synchronous, active-high reset:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  scan enable; 0 = display dark.
- tick_1hz  input  1  one-cycle 1 Hz strobe; used only when COLON_BLINK_EN is defined.
- seg_seconds_units  input  8  active-low pattern for digit 0; bit 7 = DP.
- seg_seconds_tens  input  8  active-low pattern for digit 1.
- seg_minutes_units  input  8  active-low pattern for digit 2.
- seg_minutes_tens  input  8  active-low pattern for digit 3.
- an  output  4  active-low anode select; an[k] drives digit k.
- seg  output  8  active-low cathode pattern.
- frame_done  output  1  one-cycle pulse at the end of each full scan frame.

Function
REQ-004 The block SHALL be a two-state FSM, BLANK and DRIVE, with a 2-bit digit index (0..3) and a slot cycle counter sized for max(REFRESH_DIV, BLANK_CYCLES).
REQ-005 BLANK SHALL last BLANK_CYCLES cycles with an=4'b1111 and seg=8'hFF, then go to DRIVE with the counter cleared.
REQ-006 If BLANK_CYCLES=0, BLANK SHALL be skipped entirely; each slot SHALL then be DRIVE-only.
REQ-007 DRIVE SHALL last REFRESH_DIV cycles with an=~(4'b0001<<index) and seg=shadow[index].
REQ-008 At the end of DRIVE, the index SHALL advance modulo 4 (3 wraps to 0) and the FSM SHALL enter BLANK.
REQ-009 Frame length SHALL be exactly 4*(BLANK_CYCLES+REFRESH_DIV) cycles.
REQ-010 Four 8-bit shadow registers SHALL capture all four inputs simultaneously on the first cycle of digit 0's slot (frame start), so that input changes never tear mid-frame.
REQ-011 an and seg SHALL be registered outputs that reflect the current FSM state and index, with no additional pipeline offset.
REQ-012 frame_done SHALL be high for exactly one cycle, on the last DRIVE cycle of digit 3, and low otherwise.
REQ-013 While en=0:
- an=4'b1111, seg=8'hFF, frame_done=0;
- FSM, index and counter held at their reset state.
REQ-014 When en rises, the next cycle SHALL be the first cycle of a new frame, including a shadow capture.
REQ-015 Shadow capture SHALL take precedence over any same-cycle input change: the value present on that cycle is the value captured.

Reset
REQ-016 On rst=1 at a clock edge, the block SHALL set:
- FSM=BLANK, index=0, counter=0;
- all shadows=8'hFF, an=4'b1111, seg=8'hFF, frame_done=0, blink register=0.
REQ-017 Reset mid-frame SHALL abort the scan immediately.
REQ-018 Reset SHALL override en and tick_1hz.
REQ-019 The first cycle after rst deasserts, with en=1, SHALL be a frame start.

Configuration
REQ-020 With COLON_BLINK_EN defined:
- a blink register SHALL toggle on every cycle where tick_1hz=1 and en=1;
- during digit 2's DRIVE phase, seg[7] SHALL equal ~blink, so the DP lights on alternate seconds;
- all other bits SHALL pass through from the shadow.
REQ-021 Without COLON_BLINK_EN, tick_1hz SHALL be ignored, no blink register SHALL exist, and all shadow bits, including DP, SHALL pass through unchanged.

Verification
REQ-022 Use REFRESH_DIV=4, BLANK_CYCLES=2, en=1, inputs 8'hC0/8'hF9/8'hA4/8'hB0 (digits 0..3) -> per 24-cycle frame:
- an sequence 1111x2, 1110x4, 1111x2, 1101x4, 1111x2, 1011x4, 1111x2, 0111x4;
- seg C0/F9/A4/B0 in the corresponding drive windows;
- frame_done high on cycle 24 only.
REQ-023 Change seg_minutes_tens from 8'hB0 to 8'h99 at cycle 10 of a frame -> digit 3 still shows 8'hB0 in that frame and 8'h99 in the next.
REQ-024 Use BLANK_CYCLES=0, REFRESH_DIV=1 -> an cycles 1110, 1101, 1011, 0111 every clock, and frame_done is high every 4th cycle.
REQ-025 Drop en to 0 mid-digit-1, hold 5 cycles, then raise it -> an=1111 and seg=FF while low; the first cycle after en rises is digit 0 BLANK with a fresh shadow capture.
REQ-026 Assert rst for 1 cycle during digit 2's DRIVE phase -> the next cycle shows an=1111, seg=FF, and the scan restarts at digit 0.
REQ-027 With COLON_BLINK_EN, pulse tick_1hz twice, seg_minutes_units=8'h24 -> digit 2 shows seg 8'h24 after the first tick and 8'hA4 after the second; without the macro, it shows 8'h24 throughout.
